// File: rtl/imm_encode_component_if.sv
// Request/response bundle for the immediate encoder: request side from the
// constant/offset source, response side towards instruction memory write-back.
interface imm_encode_component_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_opcode;
    logic [3:0]  req_rd;
    logic [7:0]  req_regs;
    logic [15:0] req_value;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic        err;

    modport master (
        output req_valid, req_opcode, req_rd, req_regs, req_value, out_ready,
        input  req_ready, out_valid, out_inst, err
    );

    modport slave (
        input  req_valid, req_opcode, req_rd, req_regs, req_value, out_ready,
        output req_ready, out_valid, out_inst, err
    );
endinterface

// File: rtl/imm_encode_component.sv
// Immediate encoder: turns an opcode, register fields and a 16-bit value into
// one or two instruction words whose immediate fields decode back to the value.
//
// state    | meaning
// S_IDLE   | ready for a request; illegal requests pulse err and stay here
// S_FIRST  | first (or only) word presented on out_inst
// S_SECOND | low-byte OR word of a constant load presented on out_inst
module imm_encode_component (
    input  logic                          clk,
    input  logic                          rst_n,
    imm_encode_component_if.slave         bus
);
    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND} state_t;

    state_t      state_q, state_d;
    logic [15:0] out_inst_q, out_inst_d;
    logic [15:0] second_q, second_d;
    logic        has_second_q, has_second_d;
    logic        out_valid_q, out_valid_d;
    logic        err_q, err_d;

    logic        accept;
    logic        out_hs;
    logic        legal;
    logic        need_second;
    logic [15:0] first_w;
    logic [15:0] second_w;

    assign accept = bus.req_valid && (state_q == S_IDLE);
    assign out_hs = out_valid_q && bus.out_ready;

    // Legality and word formation from the live request; only used on accept.
    always_comb begin
        legal       = 1'b0;
        need_second = 1'b0;
        first_w     = 16'h0000;
        second_w    = 16'h0000;
        case (bus.req_opcode)
            4'b1111: begin
                legal       = 1'b1;
                first_w     = {bus.req_value[15:8], bus.req_rd, 4'b0101};
                second_w    = {bus.req_value[7:0], bus.req_rd, 4'b1111};
                need_second = (bus.req_value[7:0] != 8'h00);
            end
            4'b0101: begin
                legal   = (bus.req_value[7:0] == 8'h00);
                first_w = {bus.req_value[15:8], bus.req_rd, 4'b0101};
            end
            4'b0110: begin
                legal   = !bus.req_value[0] &&
                          (bus.req_value[15:8] == {8{bus.req_value[8]}});
                first_w = {bus.req_value[8:1], bus.req_rd, 4'b0110};
            end
            4'b1000, 4'b1001, 4'b1010: begin
                legal   = (bus.req_value[15:4] == {12{bus.req_value[3]}});
                first_w = {bus.req_regs, bus.req_value[3:0], bus.req_opcode};
            end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            out_inst_q   <= 16'h0000;
            second_q     <= 16'h0000;
            has_second_q <= 1'b0;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_inst_q   <= out_inst_d;
            second_q     <= second_d;
            has_second_q <= has_second_d;
            out_valid_q  <= out_valid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept && legal) state_d = S_FIRST;
            S_FIRST:  if (out_hs) state_d = has_second_q ? S_SECOND : S_IDLE;
            S_SECOND: if (out_hs) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // out_inst only changes on accept or handshake, so it holds under backpressure.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_inst_d   = out_inst_q;
        second_d     = second_q;
        has_second_d = has_second_q;
        err_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (legal) begin
                        out_valid_d  = 1'b1;
                        out_inst_d   = first_w;
                        second_d     = second_w;
                        has_second_d = need_second;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FIRST: begin
                if (out_hs) begin
                    if (has_second_q) begin
                        out_inst_d   = second_q;
                        has_second_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            S_SECOND: begin
                if (out_hs) out_valid_d = 1'b0;
            end
            default: out_valid_d = 1'b0;
        endcase
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.err       = err_q;
endmodule
